// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a five-digit, common-anode style
// seven-segment display.
//
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYC clocks of
// every slot are blanked so that the previous digit has fully turned off
// before the next one lights (anti-ghosting). A five-slot frame lasts
// 5*SCAN_DIV clocks. Glyph codes and enables are captured into shadow
// registers only at frame start, so the picture never tears mid-frame.
//
// Ports:
//   CLK              system clock, rising edge
//   RST              synchronous, active-high reset
//   in4..in0 [3:0]   glyph codes (in0 = rightmost digit)
//                    0-9 digits, A '-', B 'L', C 'C', D 'n', E 'E', F 'P'
//   dispen   [4:0]   per-digit enable, bit k enables digit k
//   dig      [4:0]   one-hot digit select, active-high (registered)
//   seg      [6:0]   segments {g,f,e,d,c,b,a}, active-low (registered)
//   frame            one-cycle pulse the cycle after a shadow load
module seg7_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] in4,
  input  logic [3:0] in3,
  input  logic [3:0] in2,
  input  logic [3:0] in1,
  input  logic [3:0] in0,
  input  logic [4:0] dispen,
  output logic [4:0] dig,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    sh_code [5];
  logic [4:0]    sh_en;

  logic          slot_end;
  logic          frame_start;
  logic [3:0]    cur_code;
  logic          cur_en;
  logic          show;
  logic [6:0]    dec;

  assign slot_end    = (cnt == CW'(SCAN_DIV - 1));
  assign frame_start = (cnt == '0) && (idx == 3'd0);

  // Shadow selection for the digit currently being scanned.
  always_comb begin
    cur_code = sh_code[0];
    cur_en   = sh_en[0];
    case (idx)
      3'd1: begin cur_code = sh_code[1]; cur_en = sh_en[1]; end
      3'd2: begin cur_code = sh_code[2]; cur_en = sh_en[2]; end
      3'd3: begin cur_code = sh_code[3]; cur_en = sh_en[3]; end
      3'd4: begin cur_code = sh_code[4]; cur_en = sh_en[4]; end
      default: ;
    endcase
  end

  // Lit only past the blanking window and when the digit is enabled.
  assign show = (cnt >= CW'(BLANK_CYC)) && cur_en;

  // Glyph decode, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    dec = 7'h7F;
    case (cur_code)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h3F;
      4'hB: dec = 7'h47;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h2B;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0C;
      default: dec = 7'h7F;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      idx   <= 3'd0;
      for (int i = 0; i < 5; i++) sh_code[i] <= 4'd0;
      sh_en <= 5'd0;
      dig   <= 5'd0;
      seg   <= 7'h7F;
      frame <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;

      // The frame-start cycle is always blank (cnt==0), so loading the
      // shadow here never changes what is on the glass this cycle.
      if (frame_start) begin
        sh_code[0] <= in0;
        sh_code[1] <= in1;
        sh_code[2] <= in2;
        sh_code[3] <= in3;
        sh_code[4] <= in4;
        sh_en      <= dispen;
      end
      frame <= frame_start;

      dig <= show ? (5'b00001 << idx) : 5'd0;
      seg <= show ? dec : 7'h7F;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (default timing and SCAN_DIV=2) share
// stimulus. A cycle-count reference model computes expected outputs from the
// absolute position within the frame; a monitor pops and compares each cycle.
module tb_seg7_scan;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] in4, in3, in2, in1, in0;
  logic [4:0] dispen;
  logic [4:0] dig0, dig1;
  logic [6:0] seg0, seg1;
  logic       frame0, frame1;

  always #5 CLK = ~CLK;

  seg7_scan u_dut (
    .CLK(CLK), .RST(RST),
    .in4(in4), .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .dispen(dispen), .dig(dig0), .seg(seg0), .frame(frame0)
  );

  seg7_scan #(.SCAN_DIV(2), .BLANK_CYC(1)) u_fast (
    .CLK(CLK), .RST(RST),
    .in4(in4), .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .dispen(dispen), .dig(dig1), .seg(seg1), .frame(frame1)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h47,
                               7'h46, 7'h2B, 7'h06, 7'h0C};

  // {frame, dig[4:0], seg[6:0]}
  logic [12:0] exp_q0[$];
  logic [12:0] exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  // Reference model state: clocks since reset release and frame snapshot.
  int         n_m [2];
  logic [3:0] sc  [2][5];
  logic [4:0] se  [2];

  task automatic model(input int k, input int sd, input int bc,
                       output logic [12:0] e);
    logic [3:0] cur [5];
    int   pos, slot;
    logic blank, fstart;
    cur = '{in0, in1, in2, in3, in4};
    if (RST) begin
      e     = {1'b0, 5'd0, 7'h7F};
      n_m[k] = 0;
      se[k]  = 5'd0;
      for (int i = 0; i < 5; i++) sc[k][i] = 4'd0;
    end else begin
      pos    = n_m[k] % sd;
      slot   = (n_m[k] / sd) % 5;
      fstart = (pos == 0) && (slot == 0);
      blank  = (pos < bc) || !se[k][slot];
      e = {fstart, blank ? 5'd0 : (5'd1 << slot),
           blank ? 7'h7F : seg_tab[sc[k][slot]]};
      if (fstart) begin
        se[k] = dispen;
        for (int i = 0; i < 5; i++) sc[k][i] = cur[i];
      end
      n_m[k]++;
    end
  endtask

  // Inputs are already set for the coming rising edge; push what each DUT
  // must show after that edge, then move to the next falling edge.
  task automatic cyc_step();
    logic [12:0] e;
    model(0, 4, 1, e);
    exp_q0.push_back(e);
    model(1, 2, 1, e);
    exp_q1.push_back(e);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    repeat (n) cyc_step();
  endtask

  task automatic set_in(input logic [3:0] c4, input logic [3:0] c3,
                        input logic [3:0] c2, input logic [3:0] c1,
                        input logic [3:0] c0, input logic [4:0] en);
    in4 = c4; in3 = c3; in2 = c2; in1 = c1; in0 = c0; dispen = en;
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    run(1);
    RST = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [4:0] prev0 = 5'd0, prev1 = 5'd0;
  int mcyc = 0;
  int last_f0 = -1, last_f1 = -1;

  task automatic check(input string nm, input logic [12:0] got,
                       input logic [12:0] exp, inout logic [4:0] prev);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got frame=%b dig=%b seg=%h, expected frame=%b dig=%b seg=%h",
               nm, mcyc, got[12], got[11:7], got[6:0], exp[12], exp[11:7], exp[6:0]);
    end
    n_cmp++;
    if ($countones(got[11:7]) > 1) begin
      n_bad++;
      $display("FAIL %s_onehot cyc %0d: dig=%b, expected at most one bit", nm, mcyc, got[11:7]);
    end
    n_cmp++;
    if (got[11:7] != 5'd0 && prev != 5'd0 && got[11:7] != prev) begin
      n_bad++;
      $display("FAIL %s_ghost cyc %0d: dig %b followed %b, expected a blank gap",
               nm, mcyc, got[11:7], prev);
    end
    prev = got[11:7];
  endtask

  always @(posedge CLK) begin
    #1;
    if (!done) begin
      mcyc++;
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_underflow cyc %0d: sizes %0d/%0d, expected nonzero",
                 mcyc, exp_q0.size(), exp_q1.size());
      end else begin
        check("scan_div4", {frame0, dig0, seg0}, exp_q0.pop_front(), prev0);
        check("scan_div2", {frame1, dig1, seg1}, exp_q1.pop_front(), prev1);
      end
      // Frame period between uninterrupted frames.
      if (RST) begin
        last_f0 = -1;
        last_f1 = -1;
      end else begin
        if (frame0) begin
          if (last_f0 >= 0) begin
            n_cmp++;
            if (mcyc - last_f0 != 20) begin
              n_bad++;
              $display("FAIL period_div4 cyc %0d: got %0d, expected 20", mcyc, mcyc - last_f0);
            end
          end
          last_f0 = mcyc;
        end
        if (frame1) begin
          if (last_f1 >= 0) begin
            n_cmp++;
            if (mcyc - last_f1 != 10) begin
              n_bad++;
              $display("FAIL period_div2 cyc %0d: got %0d, expected 10", mcyc, mcyc - last_f1);
            end
          end
          last_f1 = mcyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0);
    run(3);

    // Reset release: digits 0-3 show '-', digit 4 disabled.
    set_in(4'h0, 4'hA, 4'hA, 4'hA, 4'hA, 5'b01111);
    RST = 1'b0;
    run(45);

    // "CL0SE" on all five digits.
    RST = 1'b1;
    set_in(4'hC, 4'hB, 4'h0, 4'h5, 4'hE, 5'b11111);
    run(1);
    RST = 1'b0;
    run(45);

    // Mid-frame change of in0 must wait for the next frame start.
    RST = 1'b1;
    set_in(4'h1, 4'h2, 4'h4, 4'h6, 4'h3, 5'b11111);
    run(1);
    RST = 1'b0;
    run(10);
    in0 = 4'h7;
    run(45);

    // Sparse enables with all eights.
    set_in(4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 5'b00101);
    rst_pulse();
    run(45);

    // Reset during an active slot of digit 3.
    set_in(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 5'b11111);
    rst_pulse();
    run(13);
    rst_pulse();
    run(30);

    // Randomized traffic with occasional resets.
    repeat (40) begin
      RST = ($urandom_range(0, 7) == 0);
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      run(1);
      RST = 1'b0;
      run($urandom_range(1, 40));
    end
    run(25);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks per digit slot; legal range 2..1024.
REQ-002 Parameter BLANK_CYC, default 1: blanking clocks at the start of each slot; legal range 1..SCAN_DIV-1.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 in4, in3, in2, in1, in0  input  4 each  glyph codes per digit; in0 is the rightmost digit.
REQ-006 dispen  input  5  per-digit enable; bit k enables digit k.
REQ-007 dig  output  5  digit select, one-hot, active-high; bit k drives digit k.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 frame  output  1  one-cycle pulse marking a shadow-register load.

Function
REQ-010 Slot counter cnt SHALL count 0..SCAN_DIV-1; when cnt==SCAN_DIV-1 it wraps to 0 and advances digit index idx.
REQ-011 idx SHALL step 0,1,2,3,4,0,... and advance only on slot wrap.
REQ-012 On every cycle with cnt==0 and idx==0 (frame start), the block SHALL copy in0..in4 and dispen into shadow registers and assert frame on the next cycle for exactly one cycle.
REQ-013 Shadow registers SHALL be the only source for display; input changes mid-frame SHALL NOT appear until the next frame start (no tearing).
REQ-014 dig and seg SHALL be registered: outputs at cycle t+1 reflect cnt, idx and shadow at cycle t.
REQ-015 When cnt<BLANK_CYC, dig SHALL be 5'b00000 and seg SHALL be 7'h7F.
REQ-016 When cnt>=BLANK_CYC and shadow dispen[idx]==1, dig SHALL be (1<<idx) and seg SHALL be the decode of the shadow code for idx.
REQ-017 When cnt>=BLANK_CYC and shadow dispen[idx]==0, dig SHALL be 5'b00000 and seg SHALL be 7'h7F.
REQ-018 Decode, code->seg: 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10.
REQ-019 Decode, letter codes: A '-'->3F, B 'L'->47, C 'C'->46, D 'n'->2B, E 'E'->06, F 'P'->0C.
REQ-020 At most one dig bit SHALL be high in any cycle.
REQ-021 dig SHALL be low for at least BLANK_CYC cycles between any two distinct digit activations (anti-ghosting).
REQ-022 Full frame period SHALL be 5*SCAN_DIV clocks, with no dead cycles at frame wrap.

Reset
REQ-023 With RST high at a clock edge, the block SHALL set cnt=0, idx=0, shadow codes=0, shadow dispen=0, dig=0, seg=7'h7F and frame=0.
REQ-024 The first cycle after RST deasserts SHALL be a frame start: shadow loads and frame pulses on the following cycle.
REQ-025 RST asserted mid-slot SHALL force blank outputs on the next cycle with no partial-digit glitch.
REQ-026 Shadow contents SHALL NOT survive reset.

Verification
REQ-027 Reset release with in4..in0=0,A,A,A,A and dispen=01111 -> frame pulses once; dig sequence 00001,00010,00100,01000,00000 in successive slots; seg=3F on digits 0-3; dig=0 on digit 4.
REQ-028 Codes C,B,0,5,E with dispen=11111 -> digits 4..0 show 46,47,40,12,06 ("CL0SE"); one-hot dig; each slot starts with 1 blank cycle (dig=0, seg=7F).
REQ-029 Change in0 from 3 to 7 mid-frame, during idx=2 -> digit 0 keeps showing 30 until the next frame start, then shows 78.
REQ-030 dispen=00101 with all codes 8 -> dig only 00001 and 00100; seg=00 only in those slots, 7F in all others.
REQ-031 Assert RST for 1 cycle during an active slot (dig=01000) -> next cycle dig=0, seg=7F; the scan restarts at idx=0 with frame pulse timing per REQ-024.
REQ-032 SCAN_DIV=2, BLANK_CYC=1, long run -> frame period 10 clocks; dig never has more than one bit set; never two consecutive cycles with different nonzero dig values.
